mining_ctrl_param: RTL
======================

// Module: mining_ctrl_param
// PURPOSE
//  Parametrised nonce-search controller for the mining datapath. Reads a
//  multi-chunk block header from BRAM and splices the current nonce into one
//  chunk on the fly, with no BRAM write-back. Streams the chunks to the SHA core
//  through a valid/ready handshake, then checks the returned hash against a
//  run-time difficulty (count of leading zero bits). Sweeps the nonce range
//  nonce_start..nonce_end and reports found / exhausted.
// PARAMETERS
//  CHUNK_W  512  chunk width, bits
//  ADDR_W   16   BRAM address width
//  NONCE_W  32   nonce width
//  HASH_W   256  hash width
//  DIFF_W   9    difficulty field width
//  POS_W    9    nonce bit-position field width; log2(CHUNK_W)
// PORTS
//  clock         in  1        clock
//  reset         in  1        synchronous, active-low
//  start         in  1        level; rising edge in IDLE launches a search
//  abort         in  1        cancels the search in progress
//  base_addr     in  ADDR_W   BRAM address of chunk 0
//  num_chunks    in  ADDR_W   chunks per header (>=1)
//  nonce_chunk   in  ADDR_W   index of the chunk that carries the nonce
//  nonce_pos     in  POS_W    MSB bit position of the nonce within that chunk
//  difficulty    in  DIFF_W   required number of leading zero bits of the hash
//  nonce_start   in  NONCE_W  first nonce tried
//  nonce_end     in  NONCE_W  last nonce tried (inclusive)
//  mem_rd_en     out 1        BRAM read strobe
//  mem_addr      out ADDR_W   BRAM address
//  mem_rdata     in  CHUNK_W  BRAM data, valid 1 cycle after mem_rd_en
//  chunk         out CHUNK_W  chunk to the hash core
//  chunk_valid   out 1        chunk offered
//  chunk_last    out 1        last chunk of the header
//  chunk_ready   in  1        hash core accepts the chunk
//  hash_flush    out 1        1-cycle pulse on abort; resets the hash core
//  hash_in       in  HASH_W   hash result
//  hash_valid    in  1        hash_in valid (1-cycle pulse)
//  busy          out 1        1 in any state except IDLE / FOUND / EXHAUSTED
//  found         out 1        hash met the difficulty
//  exhausted     out 1        range finished with no hit
//  cfg_err       out 1        1-cycle pulse: start refused
//  nonce_out     out NONCE_W  winning nonce, valid while found=1
//  attempts      out 32       hashes checked this run; saturates at 2^32-1
// BEHAVIOUR
//  - Reset (reset=0 at a clock edge) overrides everything: state IDLE, all outputs 0.
//  - On start: config is latched; nonce=nonce_start, idx=0, attempts=0; found/exhausted cleared.
//  - cfg_err is raised instead of starting a search (stay IDLE) when any of:
//    num_chunks=0, nonce_chunk>=num_chunks, nonce_pos<NONCE_W-1, nonce_pos>=CHUNK_W.
//  - FETCH: mem_rd_en=1, mem_addr=base_addr+idx (wraps mod 2^ADDR_W) -> WAIT_RD.
//  - WAIT_RD: chunk<=mem_rdata. If idx==nonce_chunk, bits
//    [nonce_pos -: NONCE_W] are replaced by the current nonce -> ISSUE.
//  - ISSUE: chunk_valid=1 and chunk_last=(idx==num_chunks-1). chunk and
//    chunk_last stay stable until chunk_ready. On chunk_ready: if last ->
//    WAIT_HASH, else idx++ and -> FETCH. Fixed cost: 3 cycles per chunk when
//    chunk_ready is held high.
//  - WAIT_HASH: no timeout; hash_in is latched on hash_valid -> CHECK.
//    hash_valid is ignored in every other state.
//  - CHECK (1 cycle): attempts++ (saturating).
//    Hit when hash[HASH_W-1 -: min(difficulty,HASH_W)] == 0; difficulty=0
//    always hits, and difficulty>HASH_W is clamped to HASH_W.
//    Hit -> FOUND, with nonce_out=nonce and found=1.
//    Else if nonce==nonce_end -> EXHAUSTED, with exhausted=1.
//    Else nonce++ (mod 2^NONCE_W), idx=0 -> FETCH.
//  - Wrap-around: nonce_end<nonce_start sweeps through 2^NONCE_W-1 -> 0.
//    nonce_start==nonce_end tries exactly one nonce.
//  - FOUND / EXHAUSTED: flags and nonce_out hold. -> IDLE once start=0.
//    Flags persist in IDLE until the next accepted start.
//  - abort while busy: next state IDLE, hash_flush pulses, chunk_valid drops,
//    found/exhausted stay 0, attempts holds. abort in IDLE / FOUND / EXHAUSTED
//    has no effect. abort and start in the same cycle in IDLE: abort wins.
// TESTING
//  - 2 chunks, nonce_chunk=1, pos=511; hash model hits at nonce 5, start=3:
//    found=1, nonce_out=5, attempts=3, chunk1[511:480] seen as 3, 4, 5.
//  - difficulty=0 -> found after the 1st hash, nonce_out=nonce_start, attempts=1.
//  - start=FFFFFFFE, end=1, never hits -> nonces FFFFFFFE, FFFFFFFF, 0, 1;
//    exhausted=1, attempts=4.
//  - chunk_ready low for 10 cycles in ISSUE -> chunk/chunk_last stable, no BRAM read issued.
//  - abort during WAIT_HASH -> hash_flush 1 cycle, IDLE, busy=0; a late
//    hash_valid is ignored.
//  - num_chunks=0 or nonce_pos=20 -> cfg_err pulse, busy stays 0;
//    reset=0 mid-ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mining_ctrl_param.sv
// Nonce-search controller: fetches a multi-chunk block header from BRAM,
// splices the current nonce into one chunk on the fly, streams the chunks to
// the SHA core over valid/ready, and checks each returned hash against a
// leading-zero difficulty while sweeping nonce_start..nonce_end.
module mining_ctrl_param #(
    parameter int CHUNK_W = 512,
    parameter int ADDR_W  = 16,
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256,
    parameter int DIFF_W  = 9,
    parameter int POS_W   = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  num_chunks,
    input  logic [ADDR_W-1:0]  nonce_chunk,
    input  logic [POS_W-1:0]   nonce_pos,
    input  logic [DIFF_W-1:0]  difficulty,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [CHUNK_W-1:0] mem_rdata,
    output logic [CHUNK_W-1:0] chunk,
    output logic               chunk_valid,
    output logic               chunk_last,
    input  logic               chunk_ready,
    output logic               hash_flush,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic               hash_valid,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               cfg_err,
    output logic [NONCE_W-1:0] nonce_out,
    output logic [31:0]        attempts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_HASH,
        S_CHECK,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t state, next_state;

    // Configuration captured when a search is accepted
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  num_q;
    logic [ADDR_W-1:0]  nchunk_q;
    logic [POS_W-1:0]   pos_q;
    logic [DIFF_W-1:0]  diff_q;
    logic [NONCE_W-1:0] nonce_end_q;

    // Working state of the sweep
    logic [NONCE_W-1:0] nonce_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [HASH_W-1:0]  hash_q;
    logic               start_d;

    logic               start_rise;
    logic               cfg_bad;
    logic               do_abort;
    logic               is_last;
    logic               hit;
    logic [HASH_W-1:0]  hit_mask;
    logic [CHUNK_W-1:0] spliced;

    assign start_rise = start & ~start_d;
    assign cfg_bad    = (num_chunks == '0)
                     || (nonce_chunk >= num_chunks)
                     || (int'(nonce_pos) < NONCE_W - 1)
                     || (int'(nonce_pos) >= CHUNK_W);
    assign busy       = (state != S_IDLE) && (state != S_FOUND) && (state != S_EXHAUSTED);
    assign do_abort   = busy & abort;
    assign is_last    = (idx_q == num_q - ADDR_W'(1));

    // Top min(difficulty, HASH_W) bits of the hash must all be zero
    always_comb begin
        hit_mask = '1;
        if (int'(diff_q) < HASH_W)
            hit_mask = ~({HASH_W{1'b1}} >> diff_q);
        hit = ((hash_q & hit_mask) == '0);
    end

    // Overlay the current nonce onto the chunk that carries it
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        spliced = mem_rdata;
        if (idx_q == nchunk_q)
            spliced[pos_q -: NONCE_W] = nonce_q;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic and handshake/BRAM strobes
    always_comb begin
        next_state  = state;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        chunk_valid = 1'b0;
        chunk_last  = 1'b0;
        if (do_abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_rise && !abort && !cfg_bad) next_state = S_FETCH;
                end
                S_FETCH: begin
                    mem_rd_en  = 1'b1;
                    mem_addr   = base_q + idx_q;
                    next_state = S_WAIT_RD;
                end
                S_WAIT_RD: next_state = S_ISSUE;
                S_ISSUE: begin
                    chunk_valid = 1'b1;
                    chunk_last  = is_last;
                    if (chunk_ready) next_state = is_last ? S_WAIT_HASH : S_FETCH;
                end
                S_WAIT_HASH: begin
                    if (hash_valid) next_state = S_CHECK;
                end
                S_CHECK: begin
                    if (hit)                        next_state = S_FOUND;
                    else if (nonce_q == nonce_end_q) next_state = S_EXHAUSTED;
                    else                            next_state = S_FETCH;
                end
                S_FOUND, S_EXHAUSTED: begin
                    if (!start) next_state = S_IDLE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: config latch, chunk splice, nonce sweep, result flags
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            start_d     <= 1'b0;
            base_q      <= '0;
            num_q       <= '0;
            nchunk_q    <= '0;
            pos_q       <= '0;
            diff_q      <= '0;
            nonce_end_q <= '0;
            nonce_q     <= '0;
            idx_q       <= '0;
            hash_q      <= '0;
            chunk       <= '0;
            hash_flush  <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            cfg_err     <= 1'b0;
            nonce_out   <= '0;
            attempts    <= '0;
        end else begin
            start_d    <= start;
            cfg_err    <= 1'b0;
            hash_flush <= do_abort;
            if (!do_abort) begin
                case (state)
                    S_IDLE: begin
                        if (start_rise && !abort) begin
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                base_q      <= base_addr;
                                num_q       <= num_chunks;
                                nchunk_q    <= nonce_chunk;
                                pos_q       <= nonce_pos;
                                diff_q      <= difficulty;
                                nonce_end_q <= nonce_end;
                                nonce_q     <= nonce_start;
                                idx_q       <= '0;
                                attempts    <= '0;
                                found       <= 1'b0;
                                exhausted   <= 1'b0;
                                nonce_out   <= '0;
                            end
                        end
                    end
                    S_WAIT_RD: chunk <= spliced;
                    S_ISSUE: begin
                        if (chunk_ready && !is_last) idx_q <= idx_q + ADDR_W'(1);
                    end
                    S_WAIT_HASH: begin
                        if (hash_valid) hash_q <= hash_in;
                    end
                    S_CHECK: begin
                        if (attempts != '1) attempts <= attempts + 32'd1;
                        if (hit) begin
                            found     <= 1'b1;
                            nonce_out <= nonce_q;
                        end else if (nonce_q == nonce_end_q) begin
                            exhausted <= 1'b1;
                        end else begin
                            nonce_q <= nonce_q + NONCE_W'(1);
                            idx_q   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
